// File: rtl/read_stage.sv
// Decode/operand-read pipeline stage: indexes the register file, resolves
// operands with EX/WB forwarding and registers the result toward execute.
module read_stage #(
  parameter int unsigned D_BITS = 32,
  parameter int unsigned REG_NR = 8,
  localparam int unsigned IDX_W = $clog2(REG_NR),
  localparam int unsigned OPC_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       instr_i,
  input  logic              instr_valid_i,
  output logic              ready_o,
  output logic [IDX_W-1:0]  src_1_o,
  output logic [IDX_W-1:0]  src_2_o,
  output logic              regs_start_o,
  input  logic [D_BITS-1:0] operand_1_i,
  input  logic [D_BITS-1:0] operand_2_i,
  input  logic              ex_wen_i,
  input  logic [IDX_W-1:0]  ex_dest_i,
  input  logic [D_BITS-1:0] ex_result_i,
  input  logic              wb_wen_i,
  input  logic [IDX_W-1:0]  wb_dest_i,
  input  logic [D_BITS-1:0] wb_result_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [IDX_W-1:0]  dest_o,
  output logic [D_BITS-1:0] operand_1_o,
  output logic [D_BITS-1:0] operand_2_o
);

  logic [OPC_W-1:0]  opcode;
  logic [IDX_W-1:0]  dest;
  logic [D_BITS-1:0] res_1, res_2;

  logic              valid_q, valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [IDX_W-1:0]  dest_q, dest_d;
  logic [D_BITS-1:0] op_1_q, op_1_d;
  logic [D_BITS-1:0] op_2_q, op_2_d;

  assign opcode       = instr_i[15:9];
  assign dest         = IDX_W'(instr_i[8:6]);
  assign src_1_o      = IDX_W'(instr_i[5:3]);
  assign src_2_o      = IDX_W'(instr_i[2:0]);
  assign regs_start_o = instr_valid_i & ~stall_i;
  assign ready_o      = ~stall_i;

  // EX result is newer than WB, so it wins when both target the same register.
  always_comb begin
    res_1 = operand_1_i;
    if (ex_wen_i && (ex_dest_i == src_1_o))      res_1 = ex_result_i;
    else if (wb_wen_i && (wb_dest_i == src_1_o)) res_1 = wb_result_i;

    res_2 = operand_2_i;
    if (ex_wen_i && (ex_dest_i == src_2_o))      res_2 = ex_result_i;
    else if (wb_wen_i && (wb_dest_i == src_2_o)) res_2 = wb_result_i;
  end

  // Flush beats stall; a bubble or flush leaves all payload fields zero.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    op_1_d   = op_1_q;
    op_2_d   = op_2_q;
    if (flush_i || (!stall_i && !instr_valid_i)) begin
      valid_d  = 1'b0;
      opcode_d = '0;
      dest_d   = '0;
      op_1_d   = '0;
      op_2_d   = '0;
    end else if (!stall_i) begin
      valid_d  = 1'b1;
      opcode_d = opcode;
      dest_d   = dest;
      op_1_d   = res_1;
      op_2_d   = res_2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      dest_q   <= '0;
      op_1_q   <= '0;
      op_2_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      op_1_q   <= op_1_d;
      op_2_q   <= op_2_d;
    end
  end

  assign valid_o     = valid_q;
  assign opcode_o    = opcode_q;
  assign dest_o      = dest_q;
  assign operand_1_o = op_1_q;
  assign operand_2_o = op_2_q;

endmodule

// File: tb/tb_read_stage.sv
// Bench for read_stage: directed scenarios with literal expectations plus
// randomized traffic checked against a behavioural pipeline-register model.
module tb_read_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        ivalid = 1'b0;
  logic        ready, rstart;
  logic [2:0]  src1, src2;
  logic [31:0] opnd1, opnd2;
  logic        ex_wen = 1'b0, wb_wen = 1'b0;
  logic [2:0]  ex_dest = '0, wb_dest = '0;
  logic [31:0] ex_res = '0, wb_res = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  dest;
  logic [31:0] out1, out2;

  logic [31:0] rf [8];

  // expected contents of the output pipeline register
  logic        e_valid;
  logic [6:0]  e_opc;
  logic [2:0]  e_dest;
  logic [31:0] e_op1, e_op2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign opnd1 = rf[src1];
  assign opnd2 = rf[src2];

  read_stage dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(ivalid),
    .ready_o(ready), .src_1_o(src1), .src_2_o(src2), .regs_start_o(rstart),
    .operand_1_i(opnd1), .operand_2_i(opnd2),
    .ex_wen_i(ex_wen), .ex_dest_i(ex_dest), .ex_result_i(ex_res),
    .wb_wen_i(wb_wen), .wb_dest_i(wb_dest), .wb_result_i(wb_res),
    .stall_i(stall), .flush_i(flush), .valid_o(valid), .opcode_o(opcode),
    .dest_o(dest), .operand_1_o(out1), .operand_2_o(out2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_valid"},  32'(valid),  32'(e_valid));
    chk({tag, "_opcode"}, 32'(opcode), 32'(e_opc));
    chk({tag, "_dest"},   32'(dest),   32'(e_dest));
    chk({tag, "_op1"},    out1,        e_op1);
    chk({tag, "_op2"},    out2,        e_op2);
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, "_src1"},   32'(src1),   32'(instr[5:3]));
    chk({tag, "_src2"},   32'(src2),   32'(instr[2:0]));
    chk({tag, "_rstart"}, 32'(rstart), 32'(ivalid && !stall));
    chk({tag, "_ready"},  32'(ready),  32'(!stall));
  endtask

  function automatic logic [31:0] fwd(input logic [2:0] s);
    if (ex_wen && ex_dest == s) return ex_res;
    if (wb_wen && wb_dest == s) return wb_res;
    return rf[s];
  endfunction

  task automatic model_zero();
    e_valid = 1'b0; e_opc = '0; e_dest = '0; e_op1 = '0; e_op2 = '0;
  endtask

  // Model next state from the inputs seen before the edge, then check after it.
  task automatic tick(input string tag);
    logic        n_valid;
    logic [6:0]  n_opc;
    logic [2:0]  n_dest;
    logic [31:0] n_op1, n_op2;
    n_valid = e_valid; n_opc = e_opc; n_dest = e_dest; n_op1 = e_op1; n_op2 = e_op2;
    if (flush || (!stall && !ivalid)) begin
      n_valid = 1'b0; n_opc = '0; n_dest = '0; n_op1 = '0; n_op2 = '0;
    end else if (!stall) begin
      n_valid = 1'b1; n_opc = instr[15:9]; n_dest = instr[8:6];
      n_op1 = fwd(instr[5:3]); n_op2 = fwd(instr[2:0]);
    end
    @(posedge clk);
    #1;
    e_valid = n_valid; e_opc = n_opc; e_dest = n_dest; e_op1 = n_op1; e_op2 = n_op2;
    chk_state(tag);
  endtask

  // Pulse reset between edges; called right after a tick.
  task automatic async_reset(input string tag);
    #3 rst = 1'b0;
    #1 model_zero();
    chk_state(tag);
    chk_comb(tag);
    #2 rst = 1'b1;
  endtask

  task automatic set_in(input logic v, input logic [6:0] opc, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2,
                        input logic st, input logic fl);
    ivalid = v; instr = {opc, d, s1, s2}; stall = st; flush = fl;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 32'h100 * 32'(i);
    model_zero();
    #3 chk_state("reset");
    chk_comb("reset");
    #4 rst = 1'b1;

    // plain read
    rf[2] = 32'h11; rf[3] = 32'h22;
    set_in(1'b1, 7'h05, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
    #1 chk_comb("plain");
    tick("plain");
    chk("plain_valid_lit", 32'(valid), 32'd1);
    chk("plain_op1_lit", out1, 32'h11);
    chk("plain_op2_lit", out2, 32'h22);
    chk("plain_dest_lit", 32'(dest), 32'd1);

    // forwarding priority
    rf[4] = 32'hCC;
    set_in(1'b1, 7'h06, 3'd0, 3'd4, 3'd4, 1'b0, 1'b0);
    ex_wen = 1'b1; ex_dest = 3'd4; ex_res = 32'hAA;
    wb_wen = 1'b1; wb_dest = 3'd4; wb_res = 32'hBB;
    tick("fwd_ex");
    chk("fwd_ex_lit", out1, 32'hAA);
    chk("fwd_ex_same_lit", out2, 32'hAA);
    ex_wen = 1'b0;
    tick("fwd_wb");
    chk("fwd_wb_lit", out1, 32'hBB);
    wb_wen = 1'b0;
    tick("fwd_rf");
    chk("fwd_rf_lit", out1, 32'hCC);

    // stall holds A for three cycles, then B
    set_in(1'b1, 7'h12, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0);
    tick("stall_a");
    set_in(1'b1, 7'h34, 3'd6, 3'd3, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready_lit", 32'(ready), 32'd0);
      chk("stall_rstart_lit", 32'(rstart), 32'd0);
      tick("stall_hold");
      chk("stall_hold_opc_lit", 32'(opcode), 32'h12);
    end
    stall = 1'b0;
    tick("stall_rel");
    chk("stall_b_opc_lit", 32'(opcode), 32'h34);
    chk("stall_b_dest_lit", 32'(dest), 32'd6);

    // flush beats stall
    flush = 1'b1; stall = 1'b1;
    tick("flush");
    chk("flush_valid_lit", 32'(valid), 32'd0);
    chk("flush_op1_lit", out1, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // async reset mid-operation, then capture on first edge
    rf[1] = 32'h1234;
    set_in(1'b1, 7'h07, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
    tick("pre_rst");
    chk("pre_rst_op1_lit", out1, 32'h1234);
    async_reset("midrst");
    chk("midrst_op1_lit", out1, 32'd0);
    tick("post_rst");
    chk("post_rst_valid_lit", 32'(valid), 32'd1);

    // bubble
    ivalid = 1'b0;
    #1 chk("bubble_rstart_lit", 32'(rstart), 32'd0);
    tick("bubble");
    chk("bubble_valid_lit", 32'(valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) for (int r = 0; r < 8; r++) rf[r] = $urandom;
      ivalid  = ($urandom_range(0, 9) < 8);
      instr   = 16'($urandom);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      ex_wen  = 1'($urandom);
      ex_dest = 3'($urandom);
      ex_res  = $urandom;
      wb_wen  = 1'($urandom);
      wb_dest = 3'($urandom);
      wb_res  = $urandom;
      #1 chk_comb("rand");
      tick("rand");
      if ($urandom_range(0, 40) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/read_stage.md
READ_STAGE -- requirements
Module: read_stage

Interface
REQ-001 Parameter D_BITS, default 32, data word width.
REQ-002 Parameter REG_NR, default 8, number of general registers; register index is 3 bits.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 instr_i  input  16  instruction from fetch: [15:9] opcode, [8:6] dest, [5:3] src1, [2:0] src2.
REQ-006 instr_valid_i  input  1  instr_i holds a valid instruction this cycle.
REQ-007 ready_o  output  1  stage accepts instr_i this cycle.
REQ-008 src_1_o, src_2_o  output  3 each  register-file read indices.
REQ-009 regs_start_o  output  1  register-file read enable.
REQ-010 operand_1_i, operand_2_i  input  D_BITS each  register-file read data, combinational from src_1_o/src_2_o.
REQ-011 ex_wen_i, ex_dest_i[3], ex_result_i[D_BITS]  input  forwarding from the execute stage.
REQ-012 wb_wen_i, wb_dest_i[3], wb_result_i[D_BITS]  input  forwarding from the write-back stage (same values driven to the register file).
REQ-013 stall_i  input  1  execute stage cannot accept a new instruction.
REQ-014 flush_i  input  1  discard the instruction held in this stage (taken branch).
REQ-015 valid_o  output  1  output pipeline register holds a valid instruction.
REQ-016 opcode_o[7], dest_o[3], operand_1_o[D_BITS], operand_2_o[D_BITS]  output  registered instruction fields and resolved operands to execute.

Function
REQ-017 src_1_o = instr_i[5:3] and src_2_o = instr_i[2:0], combinational, always driven.
REQ-018 regs_start_o = instr_valid_i AND NOT stall_i, combinational.
REQ-019 ready_o = NOT stall_i, combinational.
REQ-020 Operand resolution, per operand, with fixed priority: ex_wen_i and ex_dest_i==src, then ex_result_i; else wb_wen_i and wb_dest_i==src, then wb_result_i; else operand_x_i.
REQ-021 Both operands resolve independently; src1==src2 yields identical values.
REQ-022 Capture: on a rising edge with stall_i=0 and flush_i=0, register valid_o<=instr_valid_i and opcode/dest/resolved operands <= current values.
REQ-023 Bubble: a capture with instr_valid_i=0 sets valid_o=0 and zeroes opcode_o, dest_o, operand_1_o, operand_2_o.
REQ-024 Hold: stall_i=1 and flush_i=0 keeps all output registers unchanged; instr_i is not consumed.
REQ-025 Flush has priority over stall: flush_i=1 on an edge sets valid_o=0 and zeroes all data outputs regardless of stall_i and instr_valid_i.
REQ-026 Latency: one cycle from accepted instr_i to valid_o/operands.
REQ-027 Throughput: one instruction per cycle while stall_i=0.
REQ-028 No combinational path from stall_i or flush_i to operand_1_o/operand_2_o.

Reset
REQ-029 While rst_i=0, valid_o, opcode_o, dest_o, operand_1_o and operand_2_o are 0 immediately (no clock required).
REQ-030 Combinational outputs (src_x_o, regs_start_o, ready_o) follow their equations during reset.
REQ-031 Release of rst_i mid-stream: the first rising edge after release performs a normal capture.

Verification
REQ-032 Plain read: regfile R2=0x11, R3=0x22, instr src1=2, src2=3, dest=1, valid=1, no forwarding -> next cycle valid_o=1, operand_1_o=0x11, operand_2_o=0x22, dest_o=1.
REQ-033 Forward priority: src1=4, ex_wen=1 ex_dest=4 ex_result=0xAA, wb_wen=1 wb_dest=4 wb_result=0xBB, regfile R4=0xCC -> operand_1_o=0xAA; with ex_wen=0 -> 0xBB; with both off -> 0xCC.
REQ-034 Stall: capture instr A, then stall_i=1 for 3 cycles while instr_i=B -> outputs stay A for 3 cycles, ready_o=0, regs_start_o=0; after release B appears one cycle later.
REQ-035 Flush vs stall: valid_o=1, assert flush_i=1 and stall_i=1 together -> next edge valid_o=0, all data outputs 0.
REQ-036 Async reset mid-operation: valid_o=1, operand_1_o=0x1234, drive rst_i=0 between edges -> all registered outputs 0 before next edge; release, valid instr -> captured on the first edge.
REQ-037 Bubble: instr_valid_i=0, stall_i=0 -> next edge valid_o=0, regs_start_o=0 during that cycle.
